// File: rtl/bitmap_dump.sv
// bitmap_dump: raster-order video RAM read-back as a valid/ready byte stream (optional header via BITMAP_DUMP_HDR_EN)
module bitmap_dump #(
  parameter int X_BITS     = 7,
  parameter int Y_BITS     = 7,
  parameter int DATA_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [X_BITS+Y_BITS-1:0]   addr_r,
  input  logic [DATA_WIDTH-1:0]      dout_r,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready
);
  typedef enum logic [1:0] {IDLE, HDR, SCAN, DRAIN} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, wpos;
  logic [2:0] occ;
  logic [7:0] buf0, buf1, pix, push_d;
  logic pend, pend_sof, pend_eol, pop, push, issue, start_ok, last_addr, last_pop, hdr_done;
  assign start_ok  = start & (state == IDLE) & ~done;
  assign m_valid   = cnt != 2'd0;
  assign m_data    = buf0;
  assign pop       = m_valid & m_ready;
  assign occ       = {1'b0, cnt} + {2'b0, pend} - {2'b0, pop};
  assign wpos      = cnt - {1'b0, pop};
  assign last_addr = &addr_r;
  assign last_pop  = pop & (cnt == 2'd1) & ~pend;
  assign pix       = {pend_sof, pend_eol, 6'd0} | 8'(dout_r);
  assign busy      = (state != IDLE) | done;
`ifdef BITMAP_DUMP_HDR_EN
  localparam state_t START_ST = HDR;
  logic [1:0] hcnt;
  logic       hdr_push;
  logic [7:0] hdr_byte;
  assign hdr_push = (state == HDR) & (hcnt != 2'd3) & (occ <= 3'd1);
  assign hdr_byte = hcnt == 2'd0 ? 8'hA5 : hcnt == 2'd1 ? 8'((1 << X_BITS) - 1) : 8'((1 << Y_BITS) - 1);
  assign hdr_done = pop & (cnt == 2'd1) & (hcnt == 2'd3);
  assign issue    = (state == SCAN) & (occ <= 3'd1);
  assign push     = pend | hdr_push;
  assign push_d   = hdr_push ? hdr_byte : pix;
  // header byte index, cleared whenever the header phase is not active
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hcnt <= 2'd0;
    else hcnt <= (state != HDR) ? 2'd0 : hdr_push ? hcnt + 2'd1 : hcnt;
`else
  localparam state_t START_ST = SCAN;
  assign hdr_done = 1'b0;
  // address 0 is already on addr_r in IDLE, so the start cycle itself issues the first read
  assign issue    = start_ok | ((state == SCAN) & (occ <= 3'd1));
  assign push     = pend;
  assign push_d   = pix;
`endif
  // next-state: scan until the last address is issued, then drain the buffer
  always_comb begin
    state_nx = start_ok                                   ? START_ST :
               (state == HDR   & hdr_done)                ? SCAN     :
               (state == SCAN  & issue & last_addr)       ? DRAIN    :
               (state == DRAIN & last_pop)                ? IDLE     : state;
  end
  // state, address counter and in-flight read tag (sof/eol travel with the read)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      addr_r   <= '0;
      pend     <= 1'b0;
      pend_sof <= 1'b0;
      pend_eol <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= (state == DRAIN) & last_pop;
      addr_r   <= ((state == DRAIN) & last_pop) ? '0 : (issue & ~last_addr) ? addr_r + 1'b1 : addr_r;
      pend     <= issue;
      pend_sof <= issue & (addr_r == '0);
      pend_eol <= issue & (&addr_r[X_BITS-1:0]);
    end
  // 2-entry output/skid buffer; a read is only issued when its data is sure to fit
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt  <= 2'd0;
      buf0 <= 8'd0;
      buf1 <= 8'd0;
    end else begin
      cnt  <= cnt + {1'b0, push} - {1'b0, pop};
      buf0 <= (push & (wpos == 2'd0)) ? push_d : pop ? buf1 : buf0;
      buf1 <= (push & (wpos == 2'd1)) ? push_d : buf1;
    end
endmodule

// File: tb/tb_bitmap_dump.sv
// tb_bitmap_dump: directed checks of bitmap_dump against a byte-index model of the stream
module tb_bitmap_dump;
  localparam int XB = 7, YB = 7, DW = 3, NPIX = 1 << (XB + YB);
`ifdef BITMAP_DUMP_HDR_EN
  localparam int H = 3;
`else
  localparam int H = 0;
`endif
  localparam int TOTAL = NPIX + H;
  logic clk = 0, reset_n = 0, start = 0, m_ready = 0;
  logic busy, done, m_valid;
  logic [XB+YB-1:0] addr_r;
  logic [DW-1:0] dout_r;
  logic [7:0] m_data, prev_data;
  logic prev_hold = 0;
  logic [DW-1:0] mem [NPIX];
  logic [7:0] got [TOTAL];
  int n_chk = 0, n_fail = 0, cyc = 0, ready_mode = 0;
  int acc_cnt, done_cnt, done_cyc, last_acc, busy_cyc, first_v, start_cyc, stall;

  bitmap_dump #(.X_BITS(XB), .Y_BITS(YB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .addr_r(addr_r), .dout_r(dout_r), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) dout_r <= mem[addr_r];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    int p;
    if (k < H) return k == 0 ? 8'hA5 : k == 1 ? 8'((1 << XB) - 1) : 8'((1 << YB) - 1);
    p = k - H;
    return 8'((p == 0 ? 128 : 0) + ((p % (1 << XB)) == (1 << XB) - 1 ? 64 : 0) + (p % 8));
  endfunction

  always @(negedge clk)
    if (reset_n) begin
      busy_cyc += int'(busy);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (prev_hold) chk("hold", {m_valid, m_data}, {1'b1, prev_data});
      if (m_valid && m_ready) begin
        chk("byte", m_data, exp_byte(acc_cnt));
        if (acc_cnt < TOTAL) got[acc_cnt] = m_data;
        acc_cnt++;
        last_acc = cyc;
      end
      prev_hold = m_valid & ~m_ready;
      prev_data = m_data;
    end else prev_hold = 0;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) m_ready = 1;
    else if (ready_mode == 1) m_ready = ($urandom_range(9) < 3);
    else if (acc_cnt == H + 200 && stall < 50) begin
      m_ready = 0;
      stall++;
      if (stall == 50) begin
        chk("stall_addr", addr_r, 202);
        chk("stall_head", {m_valid, m_data}, 9'h100);
      end
    end else m_ready = 1;
  end

  task automatic run(input int mode, input int abort_at, input bit restart);
    acc_cnt = 0; done_cnt = 0; busy_cyc = 0; first_v = -1; stall = 0;
    last_acc = 0; done_cyc = 0; ready_mode = mode;
    @(posedge clk); #1;
    start = 1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk); #1;
      start = restart && (cyc == start_cyc + 100);
      if (abort_at > 0 && acc_cnt >= abort_at) begin
        #1 reset_n = 0;
        #1;
        chk("abort_out", {busy, done, m_valid, addr_r, m_data}, 0);
        chk("abort_nodone", done_cnt, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1;
        return;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 3) return;
    end
    chk("timeout", 0, 1);
  endtask

  initial begin
    for (int a = 0; a < NPIX; a++) mem[a] = DW'(a % 8);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_addr", addr_r, 0);
    chk("rst_data", m_data, 0);
    reset_n = 1;
    run(0, 5000, 0);
    run(0, 0, 0);
    chk("t1_count", acc_cnt, TOTAL);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_lat", done_cyc - last_acc, 1);
    chk("t1_first_valid", first_v - start_cyc, 2);
    chk("t1_b0", got[H], 8'h80);
    chk("t1_b127", got[H+127], 8'h47);
    chk("t1_b128", got[H+128], 8'h00);
    chk("t1_blast", got[TOTAL-1], 8'h47);
`ifdef BITMAP_DUMP_HDR_EN
    chk("t6_h0", got[0], 8'hA5);
    chk("t6_h1", got[1], 8'h7F);
    chk("t6_h2", got[2], 8'h7F);
    chk("t6_busy", busy_cyc, 16391);
`else
    chk("t1_busy", busy_cyc, 16386);
`endif
    run(1, 3000, 0);
    run(2, 0, 1);
    chk("t34_count", acc_cnt, TOTAL);
    chk("t34_done_cnt", done_cnt, 1);
    chk("t34_stalled", stall, 50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
